// File: rtl/video_timing_detector.sv
// Receive-side timing detector: measures line/frame geometry of an hs/vs/de stream,
// produces pixel coordinates and declares lock once the geometry repeats.
module video_timing_detector #(
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0,
    parameter logic [3:0]  LOCK_FRAMES = 4'd2,
    parameter logic [23:0] TIMEOUT     = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic        de_i,
    output logic        de_o,
    output logic [15:0] x_pos,
    output logic [15:0] y_pos,
    output logic        frame_start,
    output logic        locked,
    output logic        lock_lost,
    output logic [15:0] h_total,
    output logic [15:0] h_active,
    output logic [15:0] v_total,
    output logic [15:0] v_active
);

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] act;
        logic [15:0] lines;
        logic [15:0] act_lines;
    } meas_t;

    typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic hs_q, vs_q, de_q, hs_p_q, vs_p_q, de_p_q;
    logic hs_lead, vs_lead, de_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            hs_p_q <= 1'b0;
            vs_p_q <= 1'b0;
            de_p_q <= 1'b0;
        end else begin
            hs_q   <= hs_i;
            vs_q   <= vs_i;
            de_q   <= de_i;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
            de_p_q <= de_q;
        end
    end

    assign hs_lead = (hs_q == HS_POL) && (hs_p_q != HS_POL);
    assign vs_lead = (vs_q == VS_POL) && (vs_p_q != VS_POL);
    assign de_fall = de_p_q && !de_q;

    // x is computed alongside de_q so both land in the same cycle as de_o.
    logic [15:0] x_q, y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= 16'd0;
            y_q <= 16'd0;
        end else begin
            if (de_i) begin
                x_q <= de_q ? sat_inc(x_q) : 16'd0;
            end
            if (vs_lead) begin
                y_q <= 16'd0;
            end else if (de_fall) begin
                y_q <= sat_inc(y_q);
            end
        end
    end

    logic [15:0] h_cnt_q, line_len_q, de_run_q, line_act_q, line_cnt_q, act_lines_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q     <= 16'd0;
            line_len_q  <= 16'd0;
            de_run_q    <= 16'd0;
            line_act_q  <= 16'd0;
            line_cnt_q  <= 16'd0;
            act_lines_q <= 16'd0;
        end else begin
            if (hs_lead) begin
                line_len_q <= sat_inc(h_cnt_q);
                h_cnt_q    <= 16'd0;
            end else begin
                h_cnt_q <= sat_inc(h_cnt_q);
            end
            if (de_q) begin
                de_run_q <= sat_inc(de_run_q);
            end else begin
                de_run_q <= 16'd0;
                if (de_fall) begin
                    line_act_q <= de_run_q;
                end
            end
            if (vs_lead) begin
                line_cnt_q  <= 16'd0;
                act_lines_q <= 16'd0;
            end else begin
                if (hs_lead) line_cnt_q <= sat_inc(line_cnt_q);
                if (de_fall) act_lines_q <= sat_inc(act_lines_q);
            end
        end
    end

    // A line or de run closing on the vs edge itself still belongs to the ending frame.
    meas_t meas;
    assign meas.len       = line_len_q;
    assign meas.act       = line_act_q;
    assign meas.lines     = hs_lead ? sat_inc(line_cnt_q) : line_cnt_q;
    assign meas.act_lines = de_fall ? sat_inc(act_lines_q) : act_lines_q;

    logic [23:0] to_cnt_q;
    logic        timeout_hit;

    assign timeout_hit = !hs_lead && (to_cnt_q == TIMEOUT - 24'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= 24'd0;
        end else if (hs_lead) begin
            to_cnt_q <= 24'd0;
        end else if (to_cnt_q != TIMEOUT) begin
            to_cnt_q <= to_cnt_q + 24'd1;
        end
    end

    state_e     state_q;
    meas_t      ref_q, pub_q;
    logic [3:0] match_q, match_inc;
    logic       lock_lost_q, frame_start_q;

    assign match_inc = match_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StSearch;
            ref_q         <= '0;
            pub_q         <= '0;
            match_q       <= 4'd0;
            lock_lost_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            lock_lost_q   <= 1'b0;
            frame_start_q <= vs_lead;
            if (timeout_hit) begin
                state_q     <= StSearch;
                match_q     <= 4'd0;
                lock_lost_q <= (state_q == StLocked);
            end else if (vs_lead) begin
                unique case (state_q)
                    StSearch: begin
                        ref_q   <= meas;
                        match_q <= 4'd0;
                        state_q <= StCheck;
                    end
                    StCheck: begin
                        if (meas == ref_q) begin
                            match_q <= match_inc;
                            if (match_inc >= LOCK_FRAMES) begin
                                state_q <= StLocked;
                                pub_q   <= meas;
                            end
                        end else begin
                            ref_q   <= meas;
                            match_q <= 4'd0;
                        end
                    end
                    StLocked: begin
                        if (meas == pub_q) begin
                            pub_q <= meas;
                        end else begin
                            state_q     <= StSearch;
                            ref_q       <= meas;
                            match_q     <= 4'd0;
                            lock_lost_q <= 1'b1;
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end
        end
    end

    assign de_o        = de_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == StLocked);
    assign lock_lost   = lock_lost_q;
    assign h_total     = pub_q.len;
    assign h_active    = pub_q.act;
    assign v_total     = pub_q.lines;
    assign v_active    = pub_q.act_lines;

endmodule

// File: tb/tb_video_timing_detector.sv
// Bench for video_timing_detector: a scaled-down stream (60x30 totals, 40x24 active)
// drives a negative-sync instance and a positive-hs-sync instance side by side.
module tb_video_timing_detector;

    localparam int H_SYNC = 1, H_BP = 9, H_ACT = 40, H_FP = 10;
    localparam int V_SYNC = 1, V_BP = 2, V_ACT = 24, V_FP = 3;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam logic [127:0] PUB = {64'd0, 16'd60, 16'd40, 16'd30, 16'd24};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sync_h, sync_v, de;
    logic hs0, hs1, vs;
    assign hs0 = ~sync_h;
    assign hs1 = sync_h;
    assign vs  = ~sync_v;

    logic        de_o0, fs0, lk0, ll0, de_o1, fs1, lk1, ll1;
    logic [15:0] x0, y0, ht0, ha0, vt0, va0, x1, y1, ht1, ha1, vt1, va1;

    video_timing_detector #(.HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(4'd2),
                            .TIMEOUT(24'd5000)) dut0 (
        .clk(clk), .rst(rst), .hs_i(hs0), .vs_i(vs), .de_i(de), .de_o(de_o0),
        .x_pos(x0), .y_pos(y0), .frame_start(fs0), .locked(lk0), .lock_lost(ll0),
        .h_total(ht0), .h_active(ha0), .v_total(vt0), .v_active(va0)
    );

    video_timing_detector #(.HS_POL(1'b1), .VS_POL(1'b0), .LOCK_FRAMES(4'd2),
                            .TIMEOUT(24'd5000)) dut1 (
        .clk(clk), .rst(rst), .hs_i(hs1), .vs_i(vs), .de_i(de), .de_o(de_o1),
        .x_pos(x1), .y_pos(y1), .frame_start(fs1), .locked(lk1), .lock_lost(ll1),
        .h_total(ht1), .h_active(ha1), .v_total(vt1), .v_active(va1)
    );

    logic [127:0] pub0, pub1, outs0, outs1;
    assign pub0  = {64'd0, ht0, ha0, vt0, va0};
    assign pub1  = {64'd0, ht1, ha1, vt1, va1};
    assign outs0 = {28'd0, de_o0, x0, y0, fs0, lk0, ll0, ht0, ha0, vt0, va0};
    assign outs1 = {28'd0, de_o1, x1, y1, fs1, lk1, ll1, ht1, ha1, vt1, va1};

    int total = 0;
    int bad = 0;

    // Monitor: event counters plus an independent coordinate model for dut0.
    int ll0_n = 0, ll1_n = 0, fs_n = 0, fs_wide = 0, px_n = 0, x_err = 0, y_err = 0;
    int exp_y = 0;
    logic fs_prev = 1'b0, de_prev = 1'b0;
    logic [15:0] prev_x = 16'd0, last_x = 16'd0, last_y = 16'd0;

    always @(negedge clk) begin
        if (ll0) ll0_n++;
        if (ll1) ll1_n++;
        if (fs0) begin
            fs_n++;
            if (fs_prev) fs_wide++;
            exp_y = 0;
        end
        if (rst) exp_y = 0;
        if (de_prev && !de_o0) exp_y++;
        if (de_o0) begin
            px_n++;
            if (de_prev ? (x0 != prev_x + 16'd1) : (x0 != 16'd0)) x_err++;
            if (int'(y0) != exp_y) y_err++;
            last_x = x0;
            last_y = y0;
        end
        prev_x  = x0;
        de_prev = de_o0;
        fs_prev = fs0;
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic tick(input logic h, input logic v, input logic d);
        @(negedge clk);
        sync_h = h;
        sync_v = v;
        de     = d;
    endtask

    logic snap_lk0, snap_lk1;
    logic [127:0] snap_pub0, snap_pub1;
    int snap_ll0, snap_ll1;

    // Snapshot is taken 3 clocks into a frame, after the opening vs edge is processed.
    task automatic send_frame(input int bp, input int act, input int fp, input int stop);
        int h_tot, t;
        logic h, v, d;
        h_tot = H_SYNC + bp + act + fp;
        t = 0;
        for (int l = 0; l < V_TOT; l++) begin
            for (int c = 0; c < h_tot; c++) begin
                if (t == stop) return;
                h = (c < H_SYNC);
                v = (l < V_SYNC);
                d = (l >= V_SYNC + V_BP) && (l < V_SYNC + V_BP + V_ACT) &&
                    (c >= H_SYNC + bp) && (c < H_SYNC + bp + act);
                tick(h, v, d);
                if (t == 3) begin
                    snap_lk0  = lk0;
                    snap_lk1  = lk1;
                    snap_pub0 = pub0;
                    snap_pub1 = pub1;
                    snap_ll0  = ll0_n;
                    snap_ll1  = ll1_n;
                end
                t++;
            end
        end
    endtask

    typedef struct {
        int           bp;
        int           act;
        int           fp;
        logic         exp_lk;
        int           exp_ll;
        logic [127:0] exp_pub;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int prev_ll0, prev_ll1, found_k;
        int px0, xe0, ye0, fsn0, fsw0;

        // Expected status at the start of each frame, i.e. after the vs edge closing the
        // previous one. Row 4 is a frame with a one-clock-shorter back porch.
        tbl[0] = '{9, 40, 10, 1'b0, 0, 128'd0};
        tbl[1] = '{9, 40, 10, 1'b0, 0, 128'd0};
        tbl[2] = '{9, 40, 10, 1'b0, 0, 128'd0};
        tbl[3] = '{9, 40, 10, 1'b1, 0, PUB};
        tbl[4] = '{8, 40, 10, 1'b1, 0, PUB};
        tbl[5] = '{9, 40, 10, 1'b0, 1, PUB};
        tbl[6] = '{9, 40, 10, 1'b0, 0, PUB};
        tbl[7] = '{9, 40, 10, 1'b0, 0, PUB};
        tbl[8] = '{9, 40, 10, 1'b1, 0, PUB};

        rst = 1'b1;
        sync_h = 1'b0;
        sync_v = 1'b0;
        de = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs dut0", outs0, 128'd0);
        chk("reset outputs dut1", outs1, 128'd0);
        rst = 1'b0;
        repeat (5) tick(1'b0, 1'b0, 1'b0);

        prev_ll0 = ll0_n;
        prev_ll1 = ll1_n;
        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].bp, tbl[i].act, tbl[i].fp, -1);
            chk($sformatf("row%0d locked0", i), 128'(snap_lk0), 128'(tbl[i].exp_lk));
            chk($sformatf("row%0d locked1", i), 128'(snap_lk1), 128'(tbl[i].exp_lk));
            chk($sformatf("row%0d pub0", i), snap_pub0, tbl[i].exp_pub);
            chk($sformatf("row%0d pub1", i), snap_pub1, tbl[i].exp_pub);
            chk($sformatf("row%0d lock_lost0", i), 128'(snap_ll0 - prev_ll0),
                128'(tbl[i].exp_ll));
            chk($sformatf("row%0d lock_lost1", i), 128'(snap_ll1 - prev_ll1),
                128'(tbl[i].exp_ll));
            prev_ll0 = snap_ll0;
            prev_ll1 = snap_ll1;
        end

        // One locked frame: coordinate sequence and frame_start width.
        px0 = px_n; xe0 = x_err; ye0 = y_err; fsn0 = fs_n; fsw0 = fs_wide;
        send_frame(H_BP, H_ACT, H_FP, -1);
        chk("coord locked", 128'(snap_lk0), 128'd1);
        chk("coord pixels", 128'(px_n - px0), 128'(H_ACT * V_ACT));
        chk("coord x errors", 128'(x_err - xe0), 128'd0);
        chk("coord y errors", 128'(y_err - ye0), 128'd0);
        chk("coord last pixel", {96'd0, last_x, last_y}, {96'd0, 16'd39, 16'd23});
        chk("frame_start count", 128'(fs_n - fsn0), 128'd1);
        chk("frame_start width", 128'(fs_wide - fsw0), 128'd0);

        // Reset mid-line (line 5, column 16) while locked.
        send_frame(H_BP, H_ACT, H_FP, 5 * 60 + 17);
        chk("pre-reset locked", 128'(lk0), 128'd1);
        chk("pre-reset coord", {95'd0, de_o0, x0, y0}, {95'd0, 1'b1, 16'd5, 16'd2});
        #2 rst = 1'b1;
        #1;
        chk("async reset dut0", outs0, 128'd0);
        chk("async reset dut1", outs1, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_frame(H_BP, H_ACT, H_FP, -1);
            chk($sformatf("relock%0d locked0", i), 128'(snap_lk0), 128'(i == 3));
            chk($sformatf("relock%0d locked1", i), 128'(snap_lk1), 128'(i == 3));
            chk($sformatf("relock%0d pub0", i), snap_pub0, (i == 3) ? PUB : 128'd0);
        end

        // Stop hs after a locked frame; last hs edge was 59 ticks before the idle loop.
        found_k = -1;
        for (int k = 1; k <= 6000; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (ll0) begin
                found_k = k;
                break;
            end
        end
        chk("timeout latency", 128'(found_k), 128'd4943);
        chk("timeout locked0", 128'(lk0), 128'd0);
        chk("timeout locked1", 128'(lk1), 128'd0);
        tick(1'b0, 1'b0, 1'b0);
        chk("timeout lock_lost width", 128'(ll0), 128'd0);
        chk("timeout pub hold", pub0, PUB);

        // Frame-to-frame alternating active width must never lock.
        for (int i = 0; i < 6; i++) begin
            send_frame(H_BP, (i % 2 == 1) ? 32 : 40, (i % 2 == 1) ? 18 : 10, -1);
            chk($sformatf("alt%0d locked0", i), 128'(snap_lk0), 128'd0);
            chk($sformatf("alt%0d locked1", i), 128'(snap_lk1), 128'd0);
        end
        chk("alt pub hold0", pub0, PUB);
        chk("alt pub hold1", pub1, PUB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_detector.md
Name: video_timing_detector

Overview:
- Receive-side counterpart of the panel timing generator.
- Watches an incoming hs/vs/de stream in the pixel clock domain and measures h_total, h_active, v_total and v_active.
- Produces pixel coordinates (x_pos/y_pos) for downstream logic and declares lock once the measured geometry is stable across consecutive frames.
- Used ahead of DVP/LCD capture logic and as a bench/hardware checker for generated timing.

Parameters:
HS_POL, 1'b0, active level of hs (sync asserted when hs == HS_POL)
VS_POL, 1'b0, active level of vs
LOCK_FRAMES, 4'd2, consecutive matching frames needed to enter LOCKED (1..15)
TIMEOUT, 24'd1000000, clocks without an hs leading edge before forced unlock

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous reset, active-high
hs_i  in  1  horizontal sync, same clock domain
vs_i  in  1  vertical sync, same clock domain
de_i  in  1  data enable
de_o  out  1  de_i delayed 1 clk, aligned with x_pos/y_pos
x_pos  out  16  pixel index within the active line
y_pos  out  16  active line index within the frame
frame_start  out  1  1-clk pulse on the vs leading edge
locked  out  1  geometry stable
lock_lost  out  1  1-clk pulse on LOCKED->SEARCH
h_total  out  16  published clocks per line
h_active  out  16  published de-high clocks per line
v_total  out  16  published lines per frame
v_active  out  16  published lines containing de

Behaviour:
- Reset is asynchronous, clk is the only clock. All outputs, counters and the FSM reset to 0 / SEARCH.
- Inputs are registered once (hs_d, vs_d, de_d); edges are detected against the previous registered value.
  - hs leading edge: hs_d becomes HS_POL.
  - vs leading edge: vs_d becomes VS_POL.
  - de_o = de_d, so latency is 1 clk.
- h_cnt counts clocks since the last hs leading edge and saturates at 16'hFFFF.
  - At an hs leading edge: line_len <= h_cnt+1, then h_cnt <= 0.
- de_run counts de_d high clocks and is latched into line_act at the de falling edge.
  - Multiple de runs in one line: the last run wins.
- line_cnt increments on each hs leading edge (saturating). act_lines increments on each de falling edge.
- x_pos / y_pos:
  - x_pos = 0 on the first de_d cycle of a run, then +1 per de_d cycle; it holds its value when de_d is low.
  - y_pos = 0 after a vs leading edge and +1 after each de falling edge. The first active line is therefore y_pos 0.
- On a vs leading edge the frame measurement set M = {line_len, line_act, line_cnt, act_lines} is captured.
  - line_cnt and act_lines then clear.
  - frame_start pulses in the same cycle as the capture.
- Simultaneous hs and vs leading edges: the line count is closed first, so v_total includes that line.
- Lock FSM, evaluated at every vs leading edge:
  - SEARCH: store M as the reference, match_cnt <= 0, go to CHECK.
  - CHECK: if M == reference, match_cnt+1; reaching LOCK_FRAMES goes to LOCKED and publishes M. If M differs, replace the reference and set match_cnt <= 0.
  - LOCKED: if M == published, re-publish and stay. If M differs, go to SEARCH, store M as the reference, pulse lock_lost.
  - locked = (state == LOCKED).
- Timeout: a no-hs counter clears on each hs leading edge. When it reaches TIMEOUT, the FSM goes to SEARCH (lock_lost pulses if it was LOCKED) and the counter holds until the next hs edge.
- Published h_total/h_active/v_total/v_active change only when LOCKED is entered or while LOCKED. They hold their last value through unlock and SEARCH.
- The first partial frame after reset or timeout is never published. Because SEARCH discards it, at least LOCK_FRAMES+1 full frames are needed to lock.
- Reset mid-frame clears everything; measurement restarts at the next edges.

Test Plan:
- 800x480 stream (H: FP 210, sync 1, BP 182, total 1193; V: FP 45, sync 1, BP 8, total 534), polarity 0, LOCK_FRAMES=2 -> locked rises at the 4th vs leading edge; h_total=1193, h_active=800, v_total=534, v_active=480.
- Same stream, coordinate check -> on the last active pixel de_o=1, x_pos=799, y_pos=479; frame_start is exactly 1 clk wide per frame.
- While locked, one frame with an H_BP of 181 -> lock_lost pulses once at that frame's vs edge, locked drops, published values stay 1193/800/534/480, and lock is regained 2 matching frames later.
- Stop hs for TIMEOUT clocks while locked (TIMEOUT=5000 in the bench) -> lock_lost pulses at count 5000 and locked=0.
- Assert rst mid-line while locked -> all outputs become 0 immediately without a clock; relock follows the normal sequence.
- HS_POL=1 with an inverted hs stream -> same measurements as the first scenario; an alternating 800/640-wide line pattern never locks.
